// File: rtl/rom_sequencer.sv
// ROM playback sequencer: walks addresses 0..last_addr, holding each word for a fixed period.
// Optional build macro ROMSEQ_PAUSE_EN adds a pause input that freezes the per-word timer.
module rom_sequencer #(
    parameter int AW = 5,
    parameter int DW = 4,
    parameter int TW = 24
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic          start,
    input  logic          stop,
    input  logic          loop,
    input  logic [AW-1:0] last_addr,
    input  logic [TW-1:0] period,
`ifdef ROMSEQ_PAUSE_EN
    input  logic          pause,
`endif
    output logic [AW-1:0] rom_addr,
    input  logic [DW-1:0] rom_data,
    output logic [DW-1:0] dout,
    output logic          dout_stb,
    output logic          busy,
    output logic          done
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        LATCH = 2'd2,
        HOLD  = 2'd3
    } state_t;

    localparam logic [TW-1:0] PMIN = TW'(3);

    state_t        state_r, state_s;
    logic [TW-1:0] timer_r, timer_s;
    logic [TW-1:0] period_r, period_s;
    logic [AW-1:0] last_r, last_s;
    logic [AW-1:0] addr_s;
    logic [DW-1:0] dout_s;
    logic          stb_s;
    logic          busy_s;
    logic          done_s;
    logic          pause_s;

`ifdef ROMSEQ_PAUSE_EN
    assign pause_s = pause;
`else
    assign pause_s = 1'b0;
`endif

    // Periods below three cycles cannot cover FETCH, LATCH and one HOLD cycle.
    function automatic logic [TW-1:0] clamp_period(input logic [TW-1:0] p);
        if (p < PMIN) begin
            return PMIN;
        end else begin
            return p;
        end
    endfunction

    // Next-state and next-output logic.
    always_comb begin
        state_s  = state_r;
        timer_s  = timer_r;
        period_s = period_r;
        last_s   = last_r;
        addr_s   = rom_addr;
        dout_s   = dout;
        stb_s    = 1'b0;
        done_s   = 1'b0;
        case (state_r)
            IDLE: begin
                addr_s = {AW{1'b0}};
                if (start && !stop) begin
                    last_s   = last_addr;
                    period_s = clamp_period(period);
                    state_s  = FETCH;
                end else begin
                    state_s = IDLE;
                end
            end
            FETCH: begin
                if (stop) begin
                    state_s = IDLE;
                    addr_s  = {AW{1'b0}};
                end else begin
                    state_s = LATCH;
                end
            end
            LATCH: begin
                if (stop) begin
                    state_s = IDLE;
                    addr_s  = {AW{1'b0}};
                end else begin
                    dout_s  = rom_data;
                    stb_s   = 1'b1;
                    timer_s = period_r - PMIN;
                    state_s = HOLD;
                end
            end
            HOLD: begin
                if (stop) begin
                    state_s = IDLE;
                    addr_s  = {AW{1'b0}};
                end else if (pause_s) begin
                    state_s = HOLD;
                end else if (timer_r != {TW{1'b0}}) begin
                    timer_s = timer_r - TW'(1);
                end else if (rom_addr != last_r) begin
                    addr_s  = rom_addr + AW'(1);
                    state_s = FETCH;
                end else if (loop) begin
                    addr_s  = {AW{1'b0}};
                    state_s = FETCH;
                end else begin
                    addr_s  = {AW{1'b0}};
                    done_s  = 1'b1;
                    state_s = IDLE;
                end
            end
            default: begin
                state_s = IDLE;
                addr_s  = {AW{1'b0}};
            end
        endcase
        busy_s = (state_s != IDLE);
    end

    // State, timer, captured configuration and registered outputs.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_r  <= IDLE;
            timer_r  <= {TW{1'b0}};
            period_r <= {TW{1'b0}};
            last_r   <= {AW{1'b0}};
            rom_addr <= {AW{1'b0}};
            dout     <= {DW{1'b0}};
            dout_stb <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            state_r  <= state_s;
            timer_r  <= timer_s;
            period_r <= period_s;
            last_r   <= last_s;
            rom_addr <= addr_s;
            dout     <= dout_s;
            dout_stb <= stb_s;
            busy     <= busy_s;
            done     <= done_s;
        end
    end

endmodule

// File: tb/tb_rom_sequencer.sv
// Scoreboard bench for rom_sequencer: expected strobes/done pulses are queued by the
// stimulus and consumed by an independent monitor. Define ROMSEQ_PAUSE_EN for the pause case.
module tb_rom_sequencer;

    logic       clk = 1'b0;
    logic       rstn = 1'b0;
    logic       start = 1'b0;
    logic       stop = 1'b0;
    logic       loop = 1'b0;
    logic [4:0] last_addr = 5'd0;
    logic [23:0] period = 24'd0;
`ifdef ROMSEQ_PAUSE_EN
    logic       pause = 1'b0;
`endif
    logic [4:0] rom_addr;
    logic [3:0] rom_data;
    logic [3:0] dout;
    logic       dout_stb;
    logic       busy;
    logic       done;

    logic [3:0] rom [32];
    int cyc = 0;
    int t0 = 0;
    int checks = 0;
    int errors = 0;

    typedef struct {
        bit         is_done;
        int         rel;
        logic [3:0] d;
    } ev_t;
    ev_t sb[$];

    rom_sequencer #(.AW(5), .DW(4), .TW(24)) dut (
        .clk(clk),
        .rstn(rstn),
        .start(start),
        .stop(stop),
        .loop(loop),
        .last_addr(last_addr),
        .period(period),
`ifdef ROMSEQ_PAUSE_EN
        .pause(pause),
`endif
        .rom_addr(rom_addr),
        .rom_data(rom_data),
        .dout(dout),
        .dout_stb(dout_stb),
        .busy(busy),
        .done(done)
    );

    always #5 clk = ~clk;

    initial begin
        for (int i = 0; i < 32; i++) rom[i] = 4'((i + 1) % 16);
    end

    always @(posedge clk) rom_data <= rom[rom_addr];
    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: every strobe or done pulse must match the head of the scoreboard.
    always @(negedge clk) begin
        if (rstn === 1'b1 && (dout_stb === 1'b1 || done === 1'b1)) begin
            ev_t e;
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL unexpected_event: stb=%0b done=%0b dout=%0d at rel cycle %0d, required none",
                         dout_stb, done, dout, cyc - t0);
            end else begin
                e = sb.pop_front();
                if ((done !== e.is_done) || (dout_stb === e.is_done) || (dout !== e.d) ||
                    ((cyc - t0) != e.rel) || (busy !== !e.is_done)) begin
                    errors++;
                    $display("FAIL event: done=%0b busy=%0b dout=%0d rel=%0d, required done=%0b busy=%0b dout=%0d rel=%0d",
                             done, busy, dout, cyc - t0, e.is_done, !e.is_done, e.d, e.rel);
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0d required %0d", name, act, req);
        end
    endtask

    task automatic exp_stb(input int c, input logic [3:0] d);
        sb.push_back('{1'b0, c, d});
    endtask

    task automatic exp_done(input int c, input logic [3:0] d);
        sb.push_back('{1'b1, c, d});
    endtask

    task automatic to_cycle(input int c);
        while ((cyc - t0) < c) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic start_play(input logic [4:0] la, input logic [23:0] p, input logic lp);
        @(posedge clk);
        #1;
        last_addr = la;
        period    = p;
        loop      = lp;
        start     = 1'b1;
        t0        = cyc;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    initial begin
        #1;
        chk("reset_rom_addr", 32'(rom_addr), 32'd0);
        chk("reset_dout", 32'(dout), 32'd0);
        chk("reset_stb", 32'(dout_stb), 32'd0);
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_done", 32'(done), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        rstn = 1'b1;

        // One-shot, four words, period 5
        exp_stb(3, 4'd1); exp_stb(8, 4'd2); exp_stb(13, 4'd3); exp_stb(18, 4'd4);
        exp_done(21, 4'd4);
        start_play(5'd3, 24'd5, 1'b0);
        to_cycle(25);
        chk("oneshot_busy_after", 32'(busy), 32'd0);
        chk("oneshot_dout_held", 32'(dout), 32'd4);
        chk("oneshot_addr_zero", 32'(rom_addr), 32'd0);
        chk("oneshot_sb_empty", 32'(sb.size()), 32'd0);

        // Looping two words, loop dropped during the addr-0 word
        exp_stb(3, 4'd1); exp_stb(7, 4'd2); exp_stb(11, 4'd1); exp_stb(15, 4'd2);
        exp_done(17, 4'd2);
        start_play(5'd1, 24'd4, 1'b1);
        to_cycle(11);
        loop = 1'b0;
        to_cycle(20);
        chk("loop_busy_after", 32'(busy), 32'd0);
        chk("loop_dout_held", 32'(dout), 32'd2);
        chk("loop_sb_empty", 32'(sb.size()), 32'd0);

        // Period clamp and full-range address wrap, then stop in FETCH
        for (int k = 0; k <= 32; k++) exp_stb(3 + 3 * k, 4'((k + 1) % 16));
        start_play(5'd31, 24'd0, 1'b1);
        to_cycle(100);
        stop = 1'b1;
        to_cycle(101);
        stop = 1'b0;
        chk("wrap_busy_after_stop", 32'(busy), 32'd0);
        chk("wrap_dout_held", 32'(dout), 32'd1);
        to_cycle(106);
        chk("wrap_sb_empty", 32'(sb.size()), 32'd0);

        // Stop during HOLD of the first word
        exp_stb(3, 4'd1);
        start_play(5'd3, 24'd10, 1'b0);
        to_cycle(6);
        stop = 1'b1;
        to_cycle(7);
        stop = 1'b0;
        chk("stop_busy", 32'(busy), 32'd0);
        chk("stop_addr", 32'(rom_addr), 32'd0);
        chk("stop_dout", 32'(dout), 32'd1);
        to_cycle(20);
        chk("stop_still_idle", 32'(busy), 32'd0);
        chk("stop_sb_empty", 32'(sb.size()), 32'd0);

        // start and stop together in IDLE
        @(posedge clk);
        #1;
        t0 = cyc;
        start = 1'b1;
        stop  = 1'b1;
        to_cycle(1);
        start = 1'b0;
        stop  = 1'b0;
        chk("startstop_busy", 32'(busy), 32'd0);
        to_cycle(6);
        chk("startstop_idle", 32'(busy), 32'd0);

`ifdef ROMSEQ_PAUSE_EN
        // Pause freezes the HOLD timer of word 1
        exp_stb(3, 4'd1); exp_stb(19, 4'd2); exp_stb(25, 4'd3); exp_stb(31, 4'd4);
        exp_done(35, 4'd4);
        start_play(5'd3, 24'd6, 1'b0);
        to_cycle(4);
        pause = 1'b1;
        to_cycle(10);
        chk("pause_busy", 32'(busy), 32'd1);
        to_cycle(14);
        pause = 1'b0;
        to_cycle(38);
        chk("pause_sb_empty", 32'(sb.size()), 32'd0);
`endif

        // Reset asserted mid-HOLD of word 2
        exp_stb(3, 4'd1); exp_stb(8, 4'd2);
        start_play(5'd3, 24'd5, 1'b0);
        to_cycle(9);
        chk("pre_reset_addr", 32'(rom_addr), 32'd1);
        rstn = 1'b0;
        #1;
        chk("midreset_addr", 32'(rom_addr), 32'd0);
        chk("midreset_dout", 32'(dout), 32'd0);
        chk("midreset_busy", 32'(busy), 32'd0);
        chk("midreset_stb", 32'(dout_stb), 32'd0);
        chk("midreset_done", 32'(done), 32'd0);
        @(posedge clk);
        #1;
        rstn = 1'b1;
        to_cycle(25);
        chk("reset_sb_empty", 32'(sb.size()), 32'd0);
        chk("reset_stays_idle", 32'(busy), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule
